box_emitter: RTL and testbench

Parametrised triangle-list generator for one axis-aligned cuboid (player sprite, obstacles, pickups). On a one-cycle `start` it latches the box extents and streams 30 vertices (10 triangles, 5 faces) to the downstream rasteriser front end over a valid/ready handshake, with per-face colour and a first-vertex-of-triangle flag. It replaces the fixed-lane, fixed-height sprite generator, sits between the game-state logic and the vertex transform pipeline, and fully supports backpressure.

---
 rtl/box_pkg.sv | 39 +++
 rtl/box_corner_lut.sv | 62 ++++++
 rtl/box_emitter.sv | 165 ++++++++++++++++
 tb/tb_box_emitter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/box_pkg.sv
// Shared types and constants for the cuboid triangle-list emitter.
// BOX_BACK_FACE_EN selects the 36-vertex variant that includes the far face.
package box_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    // One bit per axis: 0 selects the low/near corner, 1 the high/far corner.
    typedef struct packed {
        logic xsel;
        logic ysel;
        logic zsel;
    } corner_sel_t;

    typedef enum logic [2:0] {
        FACE_FRONT,
        FACE_XMIN,
        FACE_XMAX,
        FACE_Y0,
        FACE_Y1,
        FACE_BACK
    } face_t;

    localparam logic [15:0] COLOR_FRONT_DEF = 16'h0400;
    localparam logic [15:0] COLOR_SIDE_DEF  = 16'h0200;
    localparam logic [15:0] COLOR_Y0_DEF    = 16'h1404;
    localparam logic [15:0] COLOR_Y1_DEF    = 16'h2204;
    localparam logic [15:0] COLOR_BACK_DEF  = 16'h0210;

    localparam int IDX_W = 6;
`ifdef BOX_BACK_FACE_EN
    localparam int VERT_COUNT = 36;
`else
    localparam int VERT_COUNT = 30;
`endif

endpackage

// File: rtl/box_corner_lut.sv
// Combinational map from vertex index to corner select, face id and
// first-vertex-of-triangle flag. BOX_BACK_FACE_EN adds indices 30-35.
module box_corner_lut
    import box_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output corner_sel_t      sel,
    output face_t            face,
    output logic             first
);

    // Two quad winding patterns, bit n = offset n within the face.
    // Pattern A: front/back style (a=x, b=y). Pattern B: side/plane style.
    localparam logic [7:0] QA_A = 8'b0011_0010;
    localparam logic [7:0] QA_B = 8'b0010_1100;
    localparam logic [7:0] QB_A = 8'b0000_1110;
    localparam logic [7:0] QB_B = 8'b0001_1100;

    logic [IDX_W-1:0] base;
    logic [2:0]       off;

    always_comb begin
        face = FACE_FRONT;
        base = '0;
`ifdef BOX_BACK_FACE_EN
        if (idx >= IDX_W'(30)) begin
            face = FACE_BACK;
            base = IDX_W'(30);
        end else
`endif
        if (idx >= IDX_W'(24)) begin
            face = FACE_Y1;
            base = IDX_W'(24);
        end else if (idx >= IDX_W'(18)) begin
            face = FACE_Y0;
            base = IDX_W'(18);
        end else if (idx >= IDX_W'(12)) begin
            face = FACE_XMAX;
            base = IDX_W'(12);
        end else if (idx >= IDX_W'(6)) begin
            face = FACE_XMIN;
            base = IDX_W'(6);
        end
    end

    assign off   = 3'(idx - base);
    assign first = (off == 3'd0) || (off == 3'd3);

    always_comb begin
        sel = '0;
        case (face)
            FACE_FRONT: sel = '{xsel: QA_A[off], ysel: QA_B[off], zsel: 1'b0};
            FACE_XMIN:  sel = '{xsel: 1'b0,      ysel: QB_A[off], zsel: QB_B[off]};
            FACE_XMAX:  sel = '{xsel: 1'b1,      ysel: QB_A[off], zsel: QB_B[off]};
            FACE_Y0:    sel = '{xsel: QB_A[off], ysel: 1'b0,      zsel: QB_B[off]};
            FACE_Y1:    sel = '{xsel: QB_A[off], ysel: 1'b1,      zsel: QB_B[off]};
            FACE_BACK:  sel = '{xsel: QA_A[off], ysel: QA_B[off], zsel: 1'b1};
            default:    sel = '0;
        endcase
    end

endmodule

// File: rtl/box_emitter.sv
// Streams the triangle list of one axis-aligned cuboid over valid/ready.
// BOX_BACK_FACE_EN (via box_pkg) adds the far face, 36 vertices in total.
module box_emitter
    import box_pkg::*;
#(
    parameter int                         COORD_W     = 16,
    parameter logic signed [COORD_W-1:0]  Z_OFFSET    = '0,
    parameter logic [15:0]                COLOR_FRONT = COLOR_FRONT_DEF,
    parameter logic [15:0]                COLOR_SIDE  = COLOR_SIDE_DEF,
    parameter logic [15:0]                COLOR_Y0    = COLOR_Y0_DEF,
    parameter logic [15:0]                COLOR_Y1    = COLOR_Y1_DEF,
    parameter logic [15:0]                COLOR_BACK  = COLOR_BACK_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic signed [COORD_W-1:0]   x_min,
    input  logic signed [COORD_W-1:0]   x_max,
    input  logic signed [COORD_W-1:0]   y_base,
    input  logic        [COORD_W-1:0]   box_height,
    input  logic signed [COORD_W-1:0]   z_near,
    input  logic signed [COORD_W-1:0]   z_far,
    output logic        [3*COORD_W-1:0] vertex,
    output logic        [15:0]          color,
    output logic                        new_triangle,
    output logic                        vertex_valid,
    input  logic                        vertex_ready,
    output logic                        busy,
    output logic                        done
);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;

    logic signed [COORD_W-1:0] x0_lat, x1_lat, y0_lat, y1_lat, n_lat, f_lat;
    logic signed [COORD_W-1:0] fx0, fx1, fy0, fy1, fn, ff;
    logic signed [COORD_W-1:0] sx0, sx1, sy0, sy1, sn, sf;
    logic signed [COORD_W-1:0] vx, vy, vz;

    logic             accept, hs, last;
    logic [IDX_W-1:0] lut_idx;
    corner_sel_t      sel;
    face_t            face;
    logic             first;
    logic [15:0]      color_nxt;

    assign accept = (state == ST_IDLE) && start;
    assign hs     = vertex_valid && vertex_ready;
    assign last   = (idx == IDX_W'(VERT_COUNT - 1));

    // Corners as they would be latched now; wrap modulo 2^COORD_W.
    assign fx0 = x_min;
    assign fx1 = x_max;
    assign fy0 = -y_base;
    assign fy1 = -y_base - $signed(box_height);
    assign fn  = z_near + Z_OFFSET;
    assign ff  = z_far + Z_OFFSET;

    // Vertex 0 is built straight from the inputs so it is registered on the
    // accepting edge; later vertices come from the latched corners.
    assign sx0 = accept ? fx0 : x0_lat;
    assign sx1 = accept ? fx1 : x1_lat;
    assign sy0 = accept ? fy0 : y0_lat;
    assign sy1 = accept ? fy1 : y1_lat;
    assign sn  = accept ? fn  : n_lat;
    assign sf  = accept ? ff  : f_lat;

    assign lut_idx = accept ? '0 : idx + IDX_W'(1);

    box_corner_lut u_lut (
        .idx   (lut_idx),
        .sel   (sel),
        .face  (face),
        .first (first)
    );

    assign vx = sel.xsel ? sx1 : sx0;
    assign vy = sel.ysel ? sy1 : sy0;
    assign vz = sel.zsel ? sf  : sn;

    always_comb begin
        color_nxt = COLOR_FRONT;
        case (face)
            FACE_FRONT:         color_nxt = COLOR_FRONT;
            FACE_XMIN, FACE_XMAX: color_nxt = COLOR_SIDE;
            FACE_Y0:            color_nxt = COLOR_Y0;
            FACE_Y1:            color_nxt = COLOR_Y1;
            FACE_BACK:          color_nxt = COLOR_BACK;
            default:            color_nxt = COLOR_FRONT;
        endcase
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_EMIT;
                    idx_nxt   = '0;
                end
            end
            ST_EMIT: begin
                if (hs) begin
                    if (last) begin
                        state_nxt = ST_IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            x0_lat <= fx0;
            x1_lat <= fx1;
            y0_lat <= fy0;
            y1_lat <= fy1;
            n_lat  <= fn;
            f_lat  <= ff;
        end
    end

    // Output register stage: loads on accept or on a non-final handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vertex       <= '0;
            color        <= '0;
            new_triangle <= 1'b0;
            vertex_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= hs && last;
            if (accept || (hs && !last)) begin
                vertex       <= {vx, vy, vz};
                color        <= color_nxt;
                new_triangle <= first;
                vertex_valid <= 1'b1;
                busy         <= 1'b1;
            end else if (hs && last) begin
                vertex_valid <= 1'b0;
                busy         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_box_emitter.sv
// Directed, table-driven bench for box_emitter: expected vertex lists are
// written out by hand and compared cycle by cycle, including stall cycles.
module tb_box_emitter;

`ifdef BOX_BACK_FACE_EN
    localparam int NV = 36;
`else
    localparam int NV = 30;
`endif

    localparam logic [15:0] C_FR = 16'h0400;
    localparam logic [15:0] C_SD = 16'h0200;
    localparam logic [15:0] C_Y0 = 16'h1404;
    localparam logic [15:0] C_Y1 = 16'h2204;
    localparam logic [15:0] C_BK = 16'h0210;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [15:0] c;
    } vec_t;

    vec_t tab_a[NV];
    vec_t tab_b[NV];
    int   n_fill;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [15:0] x_min, x_max, y_base, z_near, z_far;
    logic        [15:0] box_height;
    logic        [47:0] vertex;
    logic        [15:0] color;
    logic               new_triangle, vertex_valid, vertex_ready, busy, done;

    int errors = 0;
    int checks = 0;

    box_emitter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .x_min        (x_min),
        .x_max        (x_max),
        .y_base       (y_base),
        .box_height   (box_height),
        .z_near       (z_near),
        .z_far        (z_far),
        .vertex       (vertex),
        .color        (color),
        .new_triangle (new_triangle),
        .vertex_valid (vertex_valid),
        .vertex_ready (vertex_ready),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                       input logic [15:0] c);
        tab_a[n_fill] = '{x: x, y: y, z: z, c: c};
        n_fill++;
    endtask

    // Box 1: X0=-16 X1=16 Y0=0 Y1=-32 N=176 F=208.
    task automatic fill_tables();
        logic [15:0] xl, xh, yl, yh, zn, zf;
        xl = 16'hFFF0; xh = 16'h0010; yl = 16'h0000; yh = 16'hFFE0;
        zn = 16'h00B0; zf = 16'h00D0;
        n_fill = 0;
        add(xl, yl, zn, C_FR); add(xh, yl, zn, C_FR); add(xl, yh, zn, C_FR);
        add(xl, yh, zn, C_FR); add(xh, yl, zn, C_FR); add(xh, yh, zn, C_FR);
        add(xl, yl, zn, C_SD); add(xl, yh, zn, C_SD); add(xl, yh, zf, C_SD);
        add(xl, yh, zf, C_SD); add(xl, yl, zf, C_SD); add(xl, yl, zn, C_SD);
        add(xh, yl, zn, C_SD); add(xh, yh, zn, C_SD); add(xh, yh, zf, C_SD);
        add(xh, yh, zf, C_SD); add(xh, yl, zf, C_SD); add(xh, yl, zn, C_SD);
        add(xl, yl, zn, C_Y0); add(xh, yl, zn, C_Y0); add(xh, yl, zf, C_Y0);
        add(xh, yl, zf, C_Y0); add(xl, yl, zf, C_Y0); add(xl, yl, zn, C_Y0);
        add(xl, yh, zn, C_Y1); add(xh, yh, zn, C_Y1); add(xh, yh, zf, C_Y1);
        add(xh, yh, zf, C_Y1); add(xl, yh, zf, C_Y1); add(xl, yh, zn, C_Y1);
`ifdef BOX_BACK_FACE_EN
        add(xl, yl, zf, C_BK); add(xh, yl, zf, C_BK); add(xl, yh, zf, C_BK);
        add(xl, yh, zf, C_BK); add(xh, yl, zf, C_BK); add(xh, yh, zf, C_BK);
`endif
        // Box 2: same x/z, y_base=7FFF, height=2 -> Y0=8001, Y1 wraps to 7FFF.
        for (int i = 0; i < NV; i++) begin
            tab_b[i] = tab_a[i];
            tab_b[i].y = (tab_a[i].y == yl) ? 16'h8001 : 16'h7FFF;
        end
    endtask

    task automatic set_box1();
        x_min = -16; x_max = 16; y_base = 0; box_height = 32;
        z_near = 176; z_far = 208;
    endtask

    task automatic set_box2();
        set_box1();
        y_base = 16'sh7FFF; box_height = 2;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vertex"}, {16'h0, vertex}, 64'h0);
        chk({tag, "_color"}, {48'h0, color}, 64'h0);
        chk({tag, "_ctrl"}, {60'h0, new_triangle, vertex_valid, busy, done}, 64'h0);
    endtask

    // Entered #1 after the edge that accepted start; leaves in the done cycle
    // (or right after asserting reset when abort_at is reached).
    task automatic stream(input int tsel, input int ready_mode, input int restart_at,
                          input int abort_at, input int exp_done, input bit chain);
        int   k;
        int   cyc;
        bit   fin;
        vec_t e;
        k = 0; cyc = 0; fin = 1'b0;
        while (!fin && cyc < 500) begin
            vertex_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            start = (cyc == restart_at);
            if (cyc == restart_at) x_min = 16'sd100;
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_zero("abort");
                fin = 1'b1;
            end else if (k < NV) begin
                e = (tsel != 0) ? tab_b[k] : tab_a[k];
                chk($sformatf("valid_%0d", k), {63'h0, vertex_valid}, 64'h1);
                chk($sformatf("busy_%0d", k), {63'h0, busy}, 64'h1);
                chk($sformatf("done_early_%0d", k), {63'h0, done}, 64'h0);
                chk($sformatf("vertex_%0d", k), {16'h0, vertex}, {16'h0, e.x, e.y, e.z});
                chk($sformatf("color_%0d", k), {48'h0, color}, {48'h0, e.c});
                chk($sformatf("newtri_%0d", k), {63'h0, new_triangle},
                    {63'h0, ((k % 3) == 0)});
            end else begin
                chk("done_pulse", {63'h0, done}, 64'h1);
                chk("busy_end", {63'h0, busy}, 64'h0);
                chk("valid_end", {63'h0, vertex_valid}, 64'h0);
                if (exp_done >= 0) chk("done_cycle", 64'(cyc), 64'(exp_done));
                if (chain) start = 1'b1;
                fin = 1'b1;
            end
            if (!fin) begin
                if (vertex_valid && vertex_ready) k++;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: got k=%0d expected %0d vertices", k, NV);
        end
    endtask

    task automatic after_done(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_once"}, {63'h0, done}, 64'h0);
        chk({tag, "_idle_valid"}, {63'h0, vertex_valid}, 64'h0);
    endtask

    initial begin
        fill_tables();
        rst_n = 1'b0; start = 1'b0; vertex_ready = 1'b0;
        x_min = 0; x_max = 0; y_base = 0; box_height = 0; z_near = 0; z_far = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Ready held high: one vertex per cycle.
        set_box1();
        do_start();
        stream(0, 0, -1, -1, NV, 1'b0);
        after_done("t1");

        // Ready toggling: every other cycle is a stall.
        set_box1();
        do_start();
        stream(0, 1, -1, -1, 2 * NV - 1, 1'b0);
        after_done("t2");

        // Second start mid-emission (with a changed x_min) must be ignored.
        set_box1();
        do_start();
        stream(0, 0, 5, -1, NV, 1'b0);
        after_done("t3");

        // Reset at vertex 14, then no done afterwards.
        set_box1();
        do_start();
        stream(0, 0, -1, 14, -1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_reset_valid", {63'h0, vertex_valid}, 64'h0);
            chk("post_reset_done", {63'h0, done}, 64'h0);
        end

        // Fresh inputs with y wrap, then a back-to-back start in the done cycle.
        set_box2();
        do_start();
        stream(1, 0, -1, -1, NV, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        stream(1, 0, -1, -1, NV, 1'b0);
        after_done("t5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
